gpio_irq: RTL and testbench
===========================

# gpio_irq

Parametrised GPIO/system-control peripheral for the 6502 I/O page. It replaces the fixed 8-bit output/input/sysctl register group with:
- a WIDTH-bit bidirectional port with per-pin direction control;
- synchronised inputs;
- per-pin rising/falling edge interrupt capture with write-1-to-clear status;
- an 8-bit sysctl register.

It sits on the CPU byte bus behind a page chip-select. Its `irq` is ORed into `CPU_IRQ`, and its `dout` feeds the registered CPU data mux.

## Interface
Parameters:
- `WIDTH`, 8: port width, 1..32.
- `SYNC_STAGES`, 2: input synchroniser flops, 2..4.
- `ID_VALUE`, 8'hA1: constant returned by the ID register.
- `DEB_DIV`, 16'd1000: debounce sample-tick divider in clk cycles, 2..65535. Used only with `GPIO_IRQ_DEBOUNCE_EN`.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs`  in  1: chip select.
- `we`  in  1: write enable, 1 = write.
- `addr`  in  5: addr[4:2] selects the register; addr[1:0] selects the byte lane.
- `din`  in  8: write data.
- `dout`  out  8: registered read data.
- `gpio_i`  in  WIDTH: raw asynchronous pin inputs.
- `gpio_o`  out  WIDTH: output data.
- `gpio_oe`  out  WIDTH: output enables (1 = drive).
- `sysctl`  out  8: system control bits (video mode, bank select).
- `irq`  out  1: level interrupt, high-true.

## Operation
Register map. Lane n covers bits [8n+7:8n]. Lanes and bits at or above WIDTH read 0 and ignore writes.
- 0 OUT: RW, drives `gpio_o`.
- 1 DIR: RW, drives `gpio_oe`.
- 2 PIN: RO, conditioned input value. This is readable whatever the DIR setting.
- 3 RISE_EN: RW, per-pin rising-edge enable.
- 4 FALL_EN: RW, per-pin falling-edge enable.
- 5 STAT: edge status. Reads return status; writing 1 to a bit clears it, writing 0 has no effect.
- 6 SYSCTL: RW on lane 0 only; other lanes read 0.
- 7 ID: RO. Lane 0 returns ID_VALUE, lane 1 returns WIDTH, other lanes return 0.

Input conditioning:
- `gpio_i` passes through SYNC_STAGES flops to give `pin_s`.
- `pin_c` equals `pin_s`, unless debounce is compiled in (see Configuration).
- `pin_p` holds `pin_c` delayed by one clock.

Edge capture:
- rise[i] = pin_c[i] & ~pin_p[i]; fall[i] = ~pin_c[i] & pin_p[i].
- STAT[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- If a set and a W1C of the same bit happen in the same cycle, set wins and the bit stays 1.
- STAT bits are sticky until cleared. Enables gate setting only: clearing an enable does not clear STAT.

Interrupt: `irq` = |STAT, taken from a register, with no combinational path from the bus.

Reset (rst_n low, asynchronous):
- OUT, DIR, RISE_EN, FALL_EN, STAT, SYSCTL, `dout` and the synchroniser/edge flops are all 0.
- Therefore `gpio_o`=0, `gpio_oe`=0, `sysctl`=0, `irq`=0.
- Because the enables reset to 0, the spurious edge caused by `pin_p` resetting to 0 never sets STAT.
- Reset asserted mid-operation (mid-write or mid-debounce) aborts everything. No partial state survives.

## Timing
- Write: takes effect at the clk edge where cs & we. Outputs change the same edge.
- Read: when cs & ~we, `dout` loads at that edge and holds until the next read. Latency is 1 clk, matching the CPU data mux's registered select.
- A read of STAT in the same cycle that a bit sets returns the pre-set value.
- Input to PIN: SYNC_STAGES clk.
- Input to STAT/`irq`: SYNC_STAGES+1 clk.
- No wait states: the block never stalls RDY.

## Configuration
- `GPIO_IRQ_DEBOUNCE_EN` defined:
  - A shared prescaler pulses `tick` every DEB_DIV clks.
  - Per pin, a 2-bit counter counts ticks on which pin_s ≠ pin_c. It resets to 0 on any tick where they are equal.
  - On the 4th consecutive differing tick, pin_c takes pin_s and the counter clears.
  - The prescaler resets to 0.
- `GPIO_IRQ_DEBOUNCE_EN` not defined: pin_c = pin_s. No prescaler or counters exist, and DEB_DIV is unused.

## Test plan
- Reset/ID: deassert rst_n, then read reg 7 lane 0 and lane 1 -> 8'hA1 and 8'h08. `gpio_o`, `gpio_oe`, `sysctl` and `irq` are all 0.
- OUT/DIR: WIDTH=12. Write OUT lane0=8'h5A and lane1=8'hFF -> `gpio_o`=12'hF5A. Readback of lane1 gives 8'h0F.
- Sync latency: with debounce off, step gpio_i[3] 0→1 -> PIN bit 3 reads 1 starting SYNC_STAGES clks later.
- Edge IRQ: RISE_EN=8'h08, raise pin 3 -> `irq`=1 at SYNC_STAGES+1 clks. Write STAT=8'h08 -> `irq`=0 next clk. A falling edge leaves `irq`=0.
- Set/clear collision: align a W1C of STAT bit 3 with a rising edge on pin 3 -> STAT reads 8'h08 and `irq` stays 1.
- Debounce (macro on, DEB_DIV=4): glitch pin 0 high for 10 clks -> PIN unchanged. Hold high for 20 clks -> PIN bit 0 = 1 after the 4th tick. Pull rst_n low mid-count -> the count is lost.

Source files
------------

// File: rtl/gpio_irq.sv
// GPIO/system-control peripheral for the 6502 I/O page: direction-controlled port,
// synchronised inputs, edge-capture interrupts with W1C status, sysctl byte. Optional: GPIO_IRQ_DEBOUNCE_EN.
module gpio_irq #(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hA1,
  parameter logic [15:0] DEB_DIV     = 16'd1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             we,
  input  logic [4:0]       addr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic [7:0]       sysctl,
  output logic             irq
);

  localparam logic [2:0] REG_OUT     = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_PIN     = 3'd2;
  localparam logic [2:0] REG_RISE_EN = 3'd3;
  localparam logic [2:0] REG_FALL_EN = 3'd4;
  localparam logic [2:0] REG_STAT    = 3'd5;
  localparam logic [2:0] REG_SYSCTL  = 3'd6;
  localparam logic [2:0] REG_ID      = 3'd7;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("gpio_irq: WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpio_irq: SYNC_STAGES must be 2..4");
  end
  if (DEB_DIV < 16'd2) begin : g_bad_div
    $error("gpio_irq: DEB_DIV must be 2..65535");
  end

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_stat;
  logic [7:0]       r_sysctl;
  logic [7:0]       r_dout;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_pin_p;

  logic             w_wr;
  logic             w_rd;
  logic [2:0]       w_sel;
  logic [1:0]       w_lane;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_pin_s;
  logic [WIDTH-1:0] w_pin_c;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd32;
  logic [7:0]       w_rdata;

  assign w_wr   = cs & we;
  assign w_rd   = cs & ~we;
  assign w_sel  = addr[4:2];
  assign w_lane = addr[1:0];

  // Byte-lane write mask and replicated write data, clipped to WIDTH
  always_comb begin
    w_mask  = '0;
    w_wdata = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_mask[i]  = ((i / 8) == int'(w_lane));
      w_wdata[i] = din[i % 8];
    end
  end

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] mask,
                                             input logic [WIDTH-1:0] data);
    return (old_v & ~mask) | (data & mask);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_sysctl  <= '0;
    end else if (w_wr) begin
      case (w_sel)
        REG_OUT:     r_out     <= merge(r_out, w_mask, w_wdata);
        REG_DIR:     r_dir     <= merge(r_dir, w_mask, w_wdata);
        REG_RISE_EN: r_rise_en <= merge(r_rise_en, w_mask, w_wdata);
        REG_FALL_EN: r_fall_en <= merge(r_fall_en, w_mask, w_wdata);
        REG_SYSCTL:  if (w_lane == 2'd0) r_sysctl <= din;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_pin_s = r_sync[SYNC_STAGES-1];

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam logic [15:0] DIV_M1 = DEB_DIV - 16'd1;

  logic [15:0]      r_presc;
  logic [1:0]       r_deb_cnt [WIDTH];
  logic [WIDTH-1:0] r_pin_c;
  logic             w_tick;

  assign w_tick = (r_presc == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_presc <= '0;
    else        r_presc <= w_tick ? DIV_M1 : r_presc - 16'd1;
  end

  // A pin only follows pin_s after four consecutive ticks that disagree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin_c <= '0;
      for (int i = 0; i < WIDTH; i++) r_deb_cnt[i] <= 2'd0;
    end else if (w_tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_pin_s[i] != r_pin_c[i]) begin
          if (r_deb_cnt[i] == 2'd3) begin
            r_pin_c[i]   <= w_pin_s[i];
            r_deb_cnt[i] <= 2'd0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 2'd1;
          end
        end else begin
          r_deb_cnt[i] <= 2'd0;
        end
      end
    end
  end

  assign w_pin_c = r_pin_c;
`else
  assign w_pin_c = w_pin_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pin_p <= '0;
    else        r_pin_p <= w_pin_c;
  end

  assign w_set = ((w_pin_c & ~r_pin_p) & r_rise_en) | ((~w_pin_c & r_pin_p) & r_fall_en);
  assign w_clr = (w_wr && (w_sel == REG_STAT)) ? (w_mask & w_wdata) : '0;

  // Set is applied after clear so a colliding edge keeps the bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stat <= '0;
    else        r_stat <= (r_stat & ~w_clr) | w_set;
  end

  always_comb begin
    w_rd32 = '0;
    case (w_sel)
      REG_OUT:     w_rd32[WIDTH-1:0] = r_out;
      REG_DIR:     w_rd32[WIDTH-1:0] = r_dir;
      REG_PIN:     w_rd32[WIDTH-1:0] = w_pin_c;
      REG_RISE_EN: w_rd32[WIDTH-1:0] = r_rise_en;
      REG_FALL_EN: w_rd32[WIDTH-1:0] = r_fall_en;
      REG_STAT:    w_rd32[WIDTH-1:0] = r_stat;
      REG_SYSCTL:  w_rd32 = {24'h000000, r_sysctl};
      REG_ID:      w_rd32 = {16'h0000, 8'(WIDTH), ID_VALUE};
      default:     w_rd32 = '0;
    endcase
  end

  assign w_rdata = w_rd32[{w_lane, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_dout <= '0;
    else if (w_rd) r_dout <= w_rdata;
  end

  assign dout    = r_dout;
  assign gpio_o  = r_out;
  assign gpio_oe = r_dir;
  assign sysctl  = r_sysctl;
  assign irq     = |r_stat;

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq (WIDTH=12): reads are scoreboarded and checked by a monitor,
// output pins are checked directly. Debounce cases run when GPIO_IRQ_DEBOUNCE_EN is defined.
module tb_gpio_irq;
  localparam int W  = 12;
  localparam int SS = 2;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam logic [15:0] DD = 16'd4;
`else
  localparam logic [15:0] DD = 16'd1000;
`endif

  localparam logic [2:0] R_OUT = 3'd0, R_DIR = 3'd1, R_PIN = 3'd2, R_RISE = 3'd3;
  localparam logic [2:0] R_FALL = 3'd4, R_STAT = 3'd5, R_SYS = 3'd6, R_ID = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cs, we;
  logic [4:0]   addr;
  logic [7:0]   din;
  logic [7:0]   dout;
  logic [W-1:0] gpio_i, gpio_o, gpio_oe;
  logic [7:0]   sysctl;
  logic         irq;

  gpio_irq #(.WIDTH(W), .SYNC_STAGES(SS), .ID_VALUE(8'hA1), .DEB_DIV(DD)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .sysctl(sysctl), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every bus read sampled at a rising edge is compared half a cycle later
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && cs && !we) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: read with no expected value, dout %0h", dout);
        end else begin
          e = sb_q.pop_front();
          check(e.name, {24'h0, dout}, {24'h0, e.exp});
        end
      end
    end
  end

  task automatic wr(input logic [2:0] r, input logic [1:0] l, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = {r, l}; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] r, input logic [1:0] l, input logic [7:0] exp,
                    input string name);
    sb_q.push_back('{name: name, exp: exp});
    cs = 1'b1; we = 1'b0; addr = {r, l};
    @(negedge clk);
    cs = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0; gpio_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_gpio_o", gpio_o, 0);
    check("rst_gpio_oe", gpio_oe, 0);
    check("rst_sysctl", sysctl, 0);
    check("rst_irq", irq, 0);
    check("rst_dout", dout, 0);

    rd(R_ID, 2'd0, 8'hA1, "id_lane0");
    rd(R_ID, 2'd1, 8'h0C, "id_lane1");
    rd(R_ID, 2'd2, 8'h00, "id_lane2");

    wr(R_OUT, 2'd0, 8'h5A);
    wr(R_OUT, 2'd1, 8'hFF);
    check("out_gpio_o", gpio_o, 12'hF5A);
    rd(R_OUT, 2'd1, 8'h0F, "out_lane1");
    rd(R_OUT, 2'd0, 8'h5A, "out_lane0");
    wr(R_OUT, 2'd2, 8'hFF);
    check("out_lane2_ignored", gpio_o, 12'hF5A);

    wr(R_DIR, 2'd0, 8'h3C);
    wr(R_DIR, 2'd1, 8'hFA);
    check("dir_gpio_oe", gpio_oe, 12'hA3C);
    rd(R_DIR, 2'd1, 8'h0A, "dir_lane1");

    wr(R_SYS, 2'd0, 8'h96);
    check("sysctl_set", sysctl, 8'h96);
    rd(R_SYS, 2'd0, 8'h96, "sysctl_rd");
    wr(R_SYS, 2'd1, 8'hFF);
    check("sysctl_lane1_ignored", sysctl, 8'h96);
    rd(R_SYS, 2'd1, 8'h00, "sysctl_lane1_rd");

`ifndef GPIO_IRQ_DEBOUNCE_EN
    // Sync latency: pin 3 steps high just before E1; pin_s is 1 after E2, seen by the E3 read
    gpio_i[3] = 1'b1;
    rd(R_PIN, 2'd0, 8'h00, "pin_lat_e1");
    rd(R_PIN, 2'd0, 8'h00, "pin_lat_e2");
    rd(R_PIN, 2'd0, 8'h08, "pin_lat_e3");
    rd(R_PIN, 2'd1, 8'h00, "pin_lane1");

    wr(R_RISE, 2'd0, 8'h08);
    gpio_i[3] = 1'b0;
    repeat (5) @(negedge clk);
    check("irq_fall_disabled", irq, 0);
    gpio_i[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("irq_early", irq, 0);
    @(negedge clk);
    check("irq_rise", irq, 1);
    rd(R_STAT, 2'd0, 8'h08, "stat_rise");
    wr(R_STAT, 2'd0, 8'h08);
    check("irq_w1c", irq, 0);
    gpio_i[3] = 1'b0;
    repeat (5) @(negedge clk);
    check("irq_after_fall", irq, 0);
    rd(R_STAT, 2'd0, 8'h00, "stat_after_fall");

    // W1C landing on the same edge as the set
    gpio_i[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(R_STAT, 2'd0, 8'h08);
    check("irq_collision", irq, 1);
    rd(R_STAT, 2'd0, 8'h08, "stat_collision");
    wr(R_STAT, 2'd0, 8'h08);
    check("irq_clear2", irq, 0);

    gpio_i[9] = 1'b1;
    repeat (4) @(negedge clk);
    wr(R_FALL, 2'd1, 8'h02);
    gpio_i[9] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd(R_STAT, 2'd1, 8'h00, "stat_preset_read");
    check("irq_fall", irq, 1);
    rd(R_STAT, 2'd1, 8'h02, "stat_fall");
    wr(R_RISE, 2'd0, 8'h00);
    wr(R_FALL, 2'd1, 8'h00);
    rd(R_STAT, 2'd1, 8'h02, "stat_sticky");
    check("irq_sticky", irq, 1);
    wr(R_STAT, 2'd1, 8'hFF);
    check("irq_clear_lane1", irq, 0);
    rd(R_STAT, 2'd1, 8'h00, "stat_cleared_lane1");

    // Asynchronous reset in the middle of a pending write
    wr(R_RISE, 2'd0, 8'h08);
    gpio_i[3] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_i[3] = 1'b1;
    repeat (4) @(negedge clk);
    check("irq_pre_rst", irq, 1);
    cs = 1'b1; we = 1'b1; addr = {R_OUT, 2'd0}; din = 8'hAA;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gpio_o", gpio_o, 0);
    check("midrst_gpio_oe", gpio_oe, 0);
    check("midrst_sysctl", sysctl, 0);
    check("midrst_irq", irq, 0);
    check("midrst_dout", dout, 0);
    cs = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(R_OUT, 2'd0, 8'h00, "midrst_out_rd");
    rd(R_STAT, 2'd0, 8'h00, "midrst_stat_rd");
`else
    rst_n = 1'b0;
    gpio_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // 10-clk glitch spans at most three ticks
    gpio_i[0] = 1'b1;
    repeat (10) @(negedge clk);
    gpio_i[0] = 1'b0;
    repeat (20) @(negedge clk);
    rd(R_PIN, 2'd0, 8'h00, "deb_glitch");
    gpio_i[0] = 1'b1;
    repeat (24) @(negedge clk);
    rd(R_PIN, 2'd0, 8'h01, "deb_hold");
    // Reset restarts the count: two ticks before and two after are not four
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rd(R_PIN, 2'd0, 8'h00, "deb_rst_lost");
`endif

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: %0d reads never observed, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
